// File: rtl/ram_phase_controller_if.sv
// ram_phase_controller_if: bundles the RX, processor, TX and RAM-port signals
// of the RAM phase controller. master = the controller, slave = its surroundings
// (UART receiver/transmitter, processor, single-port RAM).
// Ports: RX_VALID/RX_DATA, PROC_*, TX_DONE, RAM_RDATA into the controller;
//        RAM_ADDRESS/RAM_WDATA/RAM_WE, TX_DATA/TX_START, status pulses, PHASE out.
interface ram_phase_controller_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  RX_VALID;
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic [ADDR_WIDTH-1:0] PROC_ADDR;
  logic [DATA_WIDTH-1:0] PROC_WDATA;
  logic                  PROC_WE;
  logic                  PROC_DONE;
  logic                  TX_DONE;
  logic [DATA_WIDTH-1:0] RAM_RDATA;
  logic [ADDR_WIDTH-1:0] RAM_ADDRESS;
  logic [DATA_WIDTH-1:0] RAM_WDATA;
  logic                  RAM_WE;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_START;
  logic                  START_PROCESSING;
  logic                  DATA_RECEIPTION_COMPLETE_FLAG;
  logic                  UNLOAD_COMPLETE;
  logic [1:0]            PHASE;
  logic                  RX_OVERRUN;

  modport master (
    input  RX_VALID, RX_DATA, PROC_ADDR, PROC_WDATA, PROC_WE, PROC_DONE,
           TX_DONE, RAM_RDATA,
    output RAM_ADDRESS, RAM_WDATA, RAM_WE, TX_DATA, TX_START, START_PROCESSING,
           DATA_RECEIPTION_COMPLETE_FLAG, UNLOAD_COMPLETE, PHASE, RX_OVERRUN
  );

  modport slave (
    output RX_VALID, RX_DATA, PROC_ADDR, PROC_WDATA, PROC_WE, PROC_DONE,
           TX_DONE, RAM_RDATA,
    input  RAM_ADDRESS, RAM_WDATA, RAM_WE, TX_DATA, TX_START, START_PROCESSING,
           DATA_RECEIPTION_COMPLETE_FLAG, UNLOAD_COMPLETE, PHASE, RX_OVERRUN
  );
endinterface

// File: rtl/ram_phase_controller.sv
// ram_phase_controller: owns the single RAM port in turn LOAD (UART RX) -> RUN
// (processor) -> UNLOAD (UART TX). Latency: LOAD write same edge as RX_VALID;
// TX_START 3 cycles after PROC_DONE / TX_DONE. Backpressure: none on RX (bytes
// arriving outside LOAD are dropped and flagged sticky in RX_OVERRUN); unload
// paces itself on TX_DONE.
// Ports: MAIN_CLOCK, RESET_N (synchronous, active low), bus (master modport).
module ram_phase_controller #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(10)
) (
  input  logic                  MAIN_CLOCK,
  input  logic                  RESET_N,
  ram_phase_controller_if.master bus
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_RUN,
    ST_FETCH,
    ST_SEND,
    ST_WAIT_TX
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_start_q;
  logic                  start_proc_q;
  logic                  rx_complete_q;
  logic                  unload_complete_q;
  logic                  rx_overrun_q;

  always_ff @(posedge MAIN_CLOCK) begin
    if (!RESET_N) begin
      state             <= ST_LOAD;
      cnt               <= '0;
      tx_data_q         <= '0;
      tx_start_q        <= 1'b0;
      start_proc_q      <= 1'b0;
      rx_complete_q     <= 1'b0;
      unload_complete_q <= 1'b0;
      rx_overrun_q      <= 1'b0;
    end else begin
      // All status outputs are single-cycle pulses.
      tx_start_q        <= 1'b0;
      start_proc_q      <= 1'b0;
      rx_complete_q     <= 1'b0;
      unload_complete_q <= 1'b0;

      // Only LOAD has anywhere to put a received byte.
      if (bus.RX_VALID && state != ST_LOAD) begin
        rx_overrun_q <= 1'b1;
      end

      case (state)
        ST_LOAD: begin
          if (bus.RX_VALID) begin
            if (cnt == LAST_ADDR) begin
              cnt           <= '0;
              state         <= ST_RUN;
              start_proc_q  <= 1'b1;
              rx_complete_q <= 1'b1;
            end else begin
              cnt <= cnt + ADDR_WIDTH'(1);
            end
          end
        end

        ST_RUN: begin
          if (bus.PROC_DONE) begin
            cnt   <= '0;
            state <= ST_FETCH;
          end
        end

        // Address is presented here; RAM_RDATA is valid during SEND.
        ST_FETCH: state <= ST_SEND;

        ST_SEND: begin
          tx_data_q  <= bus.RAM_RDATA;
          tx_start_q <= 1'b1;
          state      <= ST_WAIT_TX;
        end

        ST_WAIT_TX: begin
          if (bus.TX_DONE) begin
            if (cnt == LAST_ADDR) begin
              cnt               <= '0;
              unload_complete_q <= 1'b1;
              state             <= ST_LOAD;
            end else begin
              cnt   <= cnt + ADDR_WIDTH'(1);
              state <= ST_FETCH;
            end
          end
        end

        default: begin
          state <= ST_LOAD;
          cnt   <= '0;
        end
      endcase
    end
  end

  // RAM port mux. Write enables are gated by RESET_N so a byte or processor
  // write presented while reset is held never reaches the RAM.
  always_comb begin
    bus.RAM_ADDRESS = cnt;
    bus.RAM_WDATA   = '0;
    bus.RAM_WE      = 1'b0;
    case (state)
      ST_LOAD: begin
        bus.RAM_WDATA = bus.RX_DATA;
        bus.RAM_WE    = bus.RX_VALID & RESET_N;
      end
      ST_RUN: begin
        bus.RAM_ADDRESS = bus.PROC_ADDR;
        bus.RAM_WDATA   = bus.PROC_WDATA;
        bus.RAM_WE      = bus.PROC_WE & RESET_N;
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    case (state)
      ST_LOAD: bus.PHASE = 2'd0;
      ST_RUN:  bus.PHASE = 2'd1;
      default: bus.PHASE = 2'd2;
    endcase
  end

  assign bus.TX_DATA                       = tx_data_q;
  assign bus.TX_START                      = tx_start_q;
  assign bus.START_PROCESSING              = start_proc_q;
  assign bus.DATA_RECEIPTION_COMPLETE_FLAG = rx_complete_q;
  assign bus.UNLOAD_COMPLETE               = unload_complete_q;
  assign bus.RX_OVERRUN                    = rx_overrun_q;

endmodule

// File: tb/tb_ram_phase_controller.sv
// Testbench for ram_phase_controller: drives full LOAD/RUN/UNLOAD frames with a
// RAM model attached, a scoreboard of expected TX bytes, and randomized noise.
module tb_ram_phase_controller;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int NB = 4;               // pass length
  localparam logic [AW-1:0] LAST = 16'd3;

  logic MAIN_CLOCK = 1'b0;
  logic RESET_N    = 1'b0;

  ram_phase_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_phase_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LAST_ADDR (LAST)
  ) dut (
    .MAIN_CLOCK(MAIN_CLOCK),
    .RESET_N   (RESET_N),
    .bus       (bus)
  );

  always #5 MAIN_CLOCK = ~MAIN_CLOCK;

  // Single-port RAM with one-cycle read latency.
  logic [7:0] mem [16];
  always @(posedge MAIN_CLOCK) begin
    if (bus.RAM_WE === 1'b1) mem[bus.RAM_ADDRESS[3:0]] <= bus.RAM_WDATA;
    bus.RAM_RDATA <= mem[bus.RAM_ADDRESS[3:0]];
  end

  // Reference model: what the RAM should hold and which bytes must go out.
  logic [7:0] ref_mem [16];
  logic [7:0] exp_q [$];
  bit         exp_ovr;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every TX_START consumes one expected byte.
  always @(negedge MAIN_CLOCK) begin
    logic [7:0] e;
    if (RESET_N === 1'b1 && bus.TX_START === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("tx_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("tx_data", 32'(bus.TX_DATA), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(posedge MAIN_CLOCK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_phase"}, 32'(bus.PHASE), 0);
    chk({tag, "_addr"}, 32'(bus.RAM_ADDRESS), 0);
    chk({tag, "_we"}, 32'(bus.RAM_WE), 0);
    chk({tag, "_txdata"}, 32'(bus.TX_DATA), 0);
    chk({tag, "_txstart"}, 32'(bus.TX_START), 0);
    chk({tag, "_sp"}, 32'(bus.START_PROCESSING), 0);
    chk({tag, "_rcf"}, 32'(bus.DATA_RECEIPTION_COMPLETE_FLAG), 0);
    chk({tag, "_uc"}, 32'(bus.UNLOAD_COMPLETE), 0);
    chk({tag, "_ovr"}, 32'(bus.RX_OVERRUN), 0);
  endtask

  // Inputs that belong to other owners, presented during LOAD: must do nothing.
  task automatic load_noise(input int idx);
    bus.PROC_DONE = 1'b1; cyc(); bus.PROC_DONE = 1'b0;
    bus.TX_DONE = 1'b1; cyc(); bus.TX_DONE = 1'b0;
    bus.PROC_WE = 1'b1; bus.PROC_ADDR = 16'($urandom_range(0, 15));
    bus.PROC_WDATA = 8'($urandom); cyc(); bus.PROC_WE = 1'b0;
    chk("load_noise_phase", 32'(bus.PHASE), 0);
    chk("load_noise_addr", 32'(bus.RAM_ADDRESS), 32'(idx));
  endtask

  task automatic load_byte(input int idx, input logic [7:0] b);
    chk("load_addr", 32'(bus.RAM_ADDRESS), 32'(idx));
    chk("load_phase", 32'(bus.PHASE), 0);
    bus.RX_VALID = 1'b1; bus.RX_DATA = b;
    cyc();
    bus.RX_VALID = 1'b0; bus.RX_DATA = 8'($urandom);
    ref_mem[idx] = b;
    chk("load_write", 32'(mem[idx]), 32'(b));
    if (idx == NB - 1) begin
      chk("start_proc", 32'(bus.START_PROCESSING), 1);
      chk("rx_complete", 32'(bus.DATA_RECEIPTION_COMPLETE_FLAG), 1);
      chk("run_phase", 32'(bus.PHASE), 1);
      cyc();
      chk("start_proc_width", 32'(bus.START_PROCESSING), 0);
      chk("rx_complete_width", 32'(bus.DATA_RECEIPTION_COMPLETE_FLAG), 0);
    end else begin
      chk("start_proc_early", 32'(bus.START_PROCESSING), 0);
    end
  endtask

  task automatic overrun_pulse();
    bus.RX_VALID = 1'b1; bus.RX_DATA = 8'hFF;
    cyc();
    bus.RX_VALID = 1'b0;
    exp_ovr = 1'b1;
    chk("overrun_set", 32'(bus.RX_OVERRUN), 1);
  endtask

  task automatic proc_write(input int a, input logic [7:0] d);
    chk("run_phase_wr", 32'(bus.PHASE), 1);
    bus.PROC_WE = 1'b1; bus.PROC_ADDR = 16'(a); bus.PROC_WDATA = d;
    cyc();
    bus.PROC_WE = 1'b0;
    ref_mem[a] = d;
  endtask

  // Ends in the cycle where the first TX_START is high.
  task automatic proc_done();
    for (int i = 0; i < NB; i++) exp_q.push_back(ref_mem[i]);
    bus.PROC_DONE = 1'b1;
    cyc();
    bus.PROC_DONE = 1'b0;
    chk("fetch_phase", 32'(bus.PHASE), 2);
    chk("fetch_addr", 32'(bus.RAM_ADDRESS), 0);
    chk("tx_start_m1", 32'(bus.TX_START), 0);
    cyc();
    chk("tx_start_m2", 32'(bus.TX_START), 0);
    cyc();
    chk("tx_start_m3", 32'(bus.TX_START), 1);
  endtask

  // Answers each TX_START with TX_DONE after 'fixed_delay' cycles (random if < 0).
  task automatic unload_pass(input int fixed_delay, input bit inject);
    int d;
    for (int i = 0; i < NB; i++) begin
      d = (fixed_delay < 0) ? int'($urandom_range(0, 6)) : fixed_delay;
      for (int c = 0; c < d; c++) begin
        if (inject && c == 1) begin
          overrun_pulse();
        end else if (inject && c == 2) begin
          bus.PROC_WE = 1'b1; bus.PROC_ADDR = 16'($urandom_range(0, 15));
          bus.PROC_WDATA = 8'($urandom);
          cyc();
          bus.PROC_WE = 1'b0;
        end else begin
          cyc();
        end
      end
      bus.TX_DONE = 1'b1;
      cyc();
      bus.TX_DONE = 1'b0;
      if (i == NB - 1) begin
        chk("unload_complete", 32'(bus.UNLOAD_COMPLETE), 1);
        chk("unload_phase", 32'(bus.PHASE), 0);
        chk("unload_cnt", 32'(bus.RAM_ADDRESS), 0);
        cyc();
        chk("unload_complete_width", 32'(bus.UNLOAD_COMPLETE), 0);
      end else begin
        chk("unload_complete_early", 32'(bus.UNLOAD_COMPLETE), 0);
        chk("unload_next_addr", 32'(bus.RAM_ADDRESS), 32'(i + 1));
        chk("tx_gap_k1", 32'(bus.TX_START), 0);
        cyc();
        chk("tx_gap_k2", 32'(bus.TX_START), 0);
        cyc();
        chk("tx_gap_k3", 32'(bus.TX_START), 1);
      end
    end
  endtask

  task automatic end_of_frame();
    for (int a = 0; a < 16; a++) chk("ram", 32'(mem[a]), 32'(ref_mem[a]));
    chk("overrun_sticky", 32'(bus.RX_OVERRUN), 32'(exp_ovr));
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic random_load();
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 3) == 0) load_noise(i);
      idle($urandom_range(0, 2));
      load_byte(i, 8'($urandom));
    end
  endtask

  task automatic random_frame();
    int nw;
    random_load();
    nw = $urandom_range(0, 3);
    for (int w = 0; w < nw; w++) begin
      idle($urandom_range(0, 1));
      proc_write($urandom_range(0, 15), 8'($urandom));
    end
    if ($urandom_range(0, 2) == 0) overrun_pulse();
    proc_done();
    unload_pass(-1, ($urandom_range(0, 2) == 0));
    end_of_frame();
  endtask

  initial begin
    for (int a = 0; a < 16; a++) begin
      mem[a] = 8'h00;
      ref_mem[a] = 8'h00;
    end
    exp_ovr = 1'b0;
    bus.RX_VALID = 1'b0; bus.RX_DATA = '0;
    bus.PROC_ADDR = '0; bus.PROC_WDATA = '0; bus.PROC_WE = 1'b0; bus.PROC_DONE = 1'b0;
    bus.TX_DONE = 1'b0;

    RESET_N = 1'b0;
    idle(2);
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    idle(1);

    // Directed frame: A1..A4, processor writes 5C to address 2, TX_DONE 10 cycles
    // after each TX_START, overruns during RUN and WAIT_TX.
    load_noise(0);
    load_byte(0, 8'hA1);
    idle(1);
    load_byte(1, 8'hA2);
    load_byte(2, 8'hA3);
    idle(2);
    load_byte(3, 8'hA4);
    overrun_pulse();
    proc_write(2, 8'h5C);
    proc_done();
    unload_pass(10, 1'b1);
    end_of_frame();

    for (int f = 0; f < 6; f++) random_frame();

    // Reset held two cycles in the middle of RUN, with a byte on RX meanwhile.
    random_load();
    proc_write($urandom_range(0, 15), 8'($urandom));
    RESET_N = 1'b0;
    bus.RX_VALID = 1'b1; bus.RX_DATA = 8'h77;
    cyc();
    check_reset_outputs("midrun_reset");
    cyc();
    check_reset_outputs("midrun_reset2");
    RESET_N = 1'b1;
    bus.RX_VALID = 1'b0;
    exp_ovr = 1'b0;
    for (int a = 0; a < 16; a++) chk("reset_no_write", 32'(mem[a]), 32'(ref_mem[a]));
    random_frame();

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
